// File: rtl/ysyx_23060096_wbu.sv
// Write-back stage: in-order result FIFO draining one entry per cycle into the
// 32x32 register file, with forwarded combinational read ports and commit pulses.
module ysyx_23060096_wbu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_wen,
    input  logic [4:0]               in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     wb_stall,
    input  logic [4:0]               rs1_addr,
    output logic [XLEN-1:0]          rs1_data,
    input  logic [4:0]               rs2_addr,
    output logic [XLEN-1:0]          rs2_data,
    output logic                     commit_valid,
    output logic                     commit_wen,
    output logic [4:0]               commit_rd,
    output logic [XLEN-1:0]          commit_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic            r_fifo_wen  [DEPTH];
    logic [4:0]      r_fifo_rd   [DEPTH];
    logic [XLEN-1:0] r_fifo_data [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_regs [32];

    logic w_push;
    logic w_pop;

    assign in_ready   = (r_count != CW'(DEPTH));
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_count != '0) && !wb_stall;
    assign fifo_count = r_count;

    // Payload storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wen[r_wr_ptr]  <= in_wen;
            r_fifo_rd[r_wr_ptr]   <= in_rd;
            r_fifo_data[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_pop && r_fifo_wen[r_rd_ptr] && (r_fifo_rd[r_rd_ptr] != 5'd0)) begin
            r_regs[r_fifo_rd[r_rd_ptr]] <= r_fifo_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
            commit_rd    <= '0;
            commit_data  <= '0;
        end else if (w_pop) begin
            commit_valid <= 1'b1;
            commit_wen   <= r_fifo_wen[r_rd_ptr];
            commit_rd    <= r_fifo_rd[r_rd_ptr];
            commit_data  <= r_fifo_data[r_rd_ptr];
        end else begin
            commit_valid <= 1'b0;
        end
    end

    // Walk live entries oldest to youngest so the youngest match wins.
    function automatic logic [XLEN-1:0] f_read(input logic [4:0] addr);
        logic [XLEN-1:0] v;
        logic [AW-1:0]   idx;
        v = r_regs[addr];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + AW'(i);
            if ((CW'(i) < r_count) && r_fifo_wen[idx] && (r_fifo_rd[idx] == addr))
                v = r_fifo_data[idx];
        end
        if (addr == 5'd0) v = '0;
        return v;
    endfunction

    always_comb begin
        rs1_data = f_read(rs1_addr);
        rs2_data = f_read(rs2_addr);
    end

endmodule
